// File: rtl/otter_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : otter_fetch_queue
// Brief    : OTTER instruction prefetch unit: fetch PC, 1-cycle memory reads,
//            and a small FIFO of {pc, instruction} pairs feeding IF_DE.
//            Optional macro OTTER_FETCH_BYPASS_EN presents a response to an
//            empty queue on out_* in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module otter_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     redirect,
  input  logic [31:0]              redirect_target,
  input  logic                     stall_D,
  output logic                     mem_rden,
  output logic [13:0]              mem_addr,
  input  logic [31:0]              mem_rdata,
  output logic                     out_valid,
  output logic [31:0]              out_ir,
  output logic [31:0]              out_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

  logic [31:0]     r_fetch_pc;
  logic            r_pending;
  logic [31:0]     r_pending_pc;
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic [31:0]     r_fifo_ir [DEPTH];
  logic [31:0]     r_fifo_pc [DEPTH];

  logic [c_CW-1:0] w_inflight;
  logic            w_issue;
  logic            w_resp;
  logic            w_head_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_fifo_pop;
  logic            w_unused_tgt;

  assign w_unused_tgt = ^redirect_target[1:0];

  // Reads in flight count against capacity so a response always has a slot.
  assign w_inflight   = r_count + c_CW'(r_pending);
  assign w_issue      = ~RESET & ~redirect & (w_inflight < c_DEPTH);
  assign w_resp       = r_pending & ~redirect & ~RESET;
  assign w_head_valid = (r_count != '0);
  assign w_pop        = out_valid & ~stall_D & ~redirect;
  assign w_fifo_pop   = w_pop & w_head_valid;

  assign mem_rden  = w_issue;
  assign mem_addr  = r_fetch_pc[15:2];
  assign occupancy = r_count;

`ifdef OTTER_FETCH_BYPASS_EN
  logic w_bypass;
  assign w_bypass  = w_resp & ~w_head_valid;
  assign out_valid = w_head_valid | w_bypass;
  assign out_ir    = w_head_valid ? r_fifo_ir[r_rd_ptr] : (w_bypass ? mem_rdata    : 32'h0);
  assign out_pc    = w_head_valid ? r_fifo_pc[r_rd_ptr] : (w_bypass ? r_pending_pc : 32'h0);
  // A bypassed response consumed by decode never enters the FIFO.
  assign w_push    = w_resp & ~(w_bypass & ~stall_D);
`else
  assign out_valid = w_head_valid;
  assign out_ir    = w_head_valid ? r_fifo_ir[r_rd_ptr] : 32'h0;
  assign out_pc    = w_head_valid ? r_fifo_pc[r_rd_ptr] : 32'h0;
  assign w_push    = w_resp;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_fetch_pc   <= RESET_PC;
      r_pending    <= 1'b0;
      r_pending_pc <= RESET_PC;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else if (redirect) begin
      r_fetch_pc <= {redirect_target[31:2], 2'b00};
      r_pending  <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_pending <= w_issue;
      if (w_issue) begin
        r_pending_pc <= r_fetch_pc;
        r_fetch_pc   <= r_fetch_pc + 32'd4;
      end
      if (w_push)
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
      if (w_fifo_pop)
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      r_count <= r_count + c_CW'(w_push) - c_CW'(w_fifo_pop);
    end
    if (!RESET)
      assert (r_count <= c_DEPTH);
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo_ir[r_wr_ptr] <= mem_rdata;
      r_fifo_pc[r_wr_ptr] <= r_pending_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_otter_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_otter_fetch_queue
// Brief    : Directed self-checking bench for otter_fetch_queue; memory word n
//            returns n. Honours OTTER_FETCH_BYPASS_EN for latency expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_otter_fetch_queue;

`ifdef OTTER_FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        stall_D = 1'b0;
  logic        mem_rden;
  logic [13:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic        out_valid;
  logic [31:0] out_ir;
  logic [31:0] out_pc;
  logic [2:0]  occupancy;
  logic        r_pend = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  otter_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .stall_D         (stall_D),
    .mem_rden        (mem_rden),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .out_valid       (out_valid),
    .out_ir          (out_ir),
    .out_pc          (out_pc),
    .occupancy       (occupancy)
  );

  always #5 CLK = ~CLK;

  // Synchronous memory model: word n holds n; r_pend mirrors a read in flight.
  always @(posedge CLK) begin
    if (mem_rden)
      mem_rdata <= {18'd0, mem_addr};
    r_pend <= mem_rden;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Unstalled stream whose first read (of base) issues in the current cycle.
  task automatic run_stream(input int n, input logic [31:0] base);
    logic [31:0] a;
    logic [31:0] p;
    for (int k = 0; k < n; k++) begin
      #1;
      a = base + 32'(4 * k);
      if (k == 0) chk("occ0", 32'(occupancy), 32'd0);
      chk("rden", 32'(mem_rden), 32'd1);
      chk("addr", 32'(mem_addr), {18'd0, a[15:2]});
      if (k < LAT) begin
        chk("vld_lo", 32'(out_valid), 32'd0);
        chk("ir_lo", out_ir, 32'h0);
        chk("pc_lo", out_pc, 32'h0);
      end else begin
        p = base + 32'(4 * (k - LAT));
        chk("vld", 32'(out_valid), 32'd1);
        chk("pc", out_pc, p);
        chk("ir", out_ir, {18'd0, p[15:2]});
      end
      next_cycle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_pc;
    logic [31:0] p;
    logic        found;

    // Reset state
    next_cycle();
    #1;
    chk("rst_rden", 32'(mem_rden), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_ir", out_ir, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    next_cycle();
    RESET = 1'b0;
    run_stream(8, 32'h0);

    // Stall for 10 cycles: head held, FIFO saturates, issue stops
    hold_pc = 32'(4 * (8 - LAT));
    stall_D = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stl_vld", 32'(out_valid), 32'd1);
      chk("stl_pc", out_pc, hold_pc);
      if (i == 9) begin
        chk("stl_occ", 32'(occupancy), 32'd4);
        chk("stl_rden", 32'(mem_rden), 32'd0);
      end
      next_cycle();
    end
    stall_D = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      p = hold_pc + 32'(4 * i);
      if (i == 0) chk("rel_rden0", 32'(mem_rden), 32'd0);
      if (i == 1) chk("rel_rden1", 32'(mem_rden), 32'd1);
      chk("rel_vld", 32'(out_valid), 32'd1);
      chk("rel_pc", out_pc, p);
      chk("rel_ir", out_ir, {18'd0, p[15:2]});
      next_cycle();
    end

    // Redirect with count = 3 and a read pending
    stall_D = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      #1;
      if (occupancy == 3'd3 && r_pend) found = 1'b1;
      else next_cycle();
    end
    chk("wait_c3", 32'(found), 32'd1);
    redirect = 1'b1;
    redirect_target = 32'h0000_0102;
    #1;
    chk("rdr_rden", 32'(mem_rden), 32'd0);
    next_cycle();
    redirect = 1'b0;
    stall_D = 1'b0;
    run_stream(4, 32'h0000_0100);

    // Redirect with stall and a full FIFO
    stall_D = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      #1;
      if (occupancy == 3'd4) found = 1'b1;
      else next_cycle();
    end
    chk("wait_full", 32'(found), 32'd1);
    redirect = 1'b1;
    redirect_target = 32'h0000_0200;
    #1;
    chk("rs_rden", 32'(mem_rden), 32'd0);
    chk("rs_vld", 32'(out_valid), 32'd1);
    next_cycle();
    redirect = 1'b0;
    #1;
    chk("rs_occ", 32'(occupancy), 32'd0);
    chk("rs_vld2", 32'(out_valid), 32'd0);
    chk("rs_addr", 32'(mem_addr), 32'h80);
    chk("rs_rden2", 32'(mem_rden), 32'd1);
    next_cycle();

    // Redirect together with RESET: RESET wins
    RESET = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'h0000_0300;
    #1;
    chk("rr_rden", 32'(mem_rden), 32'd0);
    chk("rr_vld", 32'(out_valid), 32'd0);
    next_cycle();
    RESET = 1'b0;
    redirect = 1'b0;
    stall_D = 1'b0;
    #1;
    chk("rr_addr", 32'(mem_addr), 32'h0);
    chk("rr_rden2", 32'(mem_rden), 32'd1);
    chk("rr_occ", 32'(occupancy), 32'd0);
    next_cycle();

    // RESET one cycle after an issue: response dropped, clean restart
    RESET = 1'b1;
    #1;
    chk("ri_vld", 32'(out_valid), 32'd0);
    chk("ri_rden", 32'(mem_rden), 32'd0);
    next_cycle();
    RESET = 1'b0;
    run_stream(8, 32'h0);

    // Fetch PC wrap at the top of the address space
    redirect = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    #1;
    chk("wr_rden", 32'(mem_rden), 32'd0);
    next_cycle();
    redirect = 1'b0;
    run_stream(5, 32'hFFFF_FFFC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/otter_fetch_queue.md
# otter_fetch_queue

Instruction prefetch unit for the pipelined OTTER core. It owns the fetch PC, issues word reads to the instruction port of the OTTER memory (synchronous, 1-cycle read latency), and buffers returned instructions with their PCs in a small FIFO. It sits between the instruction memory and the IF_DE pipeline register, where it replaces the bare PC register and `PC + 4` mux. It accepts branch/jump redirects from Execute and stalls from the hazard unit.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥ 2.
- `RESET_PC`, 32'h0000_0000: fetch PC after reset, word aligned.

- `CLK`  in  1  clock; all state updates on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `redirect`  in  1  Execute-stage redirect (pc_sel).
- `redirect_target`  in  32  new fetch PC; bits [1:0] ignored.
- `stall_D`  in  1  decode stall; head entry is held.
- `mem_rden`  out  1  instruction read enable.
- `mem_addr`  out  14  word address = fetch_pc[15:2].
- `mem_rdata`  in  32  instruction data, valid the cycle after `mem_rden`.
- `out_valid`  out  1  head entry valid.
- `out_ir`  out  32  head instruction; 32'h0 when `out_valid` = 0.
- `out_pc`  out  32  head PC; 32'h0 when `out_valid` = 0.
- `occupancy`  out  $clog2(DEPTH)+1  current FIFO count.

## Operation
- State: `fetch_pc`, `pending` (read in flight), `pending_pc`, FIFO storage, read/write pointers, and count. Pointers wrap modulo DEPTH.
- Issue: `mem_rden` = ~RESET & ~redirect & ((count + pending) < DEPTH). On issue, `pending_pc` <= `fetch_pc`, `fetch_pc` <= `fetch_pc` + 4, and `pending` <= 1. Otherwise `pending` <= 0.
- Response: when `pending` = 1 and `redirect` = 0, {`pending_pc`, `mem_rdata`} is pushed. When `pending` = 1 and `redirect` = 1, the response is dropped.
- Pop: `out_valid` & ~`stall_D` & ~`redirect` pops the head at the edge.
- A push and a pop in the same cycle leave count unchanged. Overflow is impossible by construction. An assertion checks it: count never exceeds DEPTH.
- Redirect (highest priority below RESET):
  - count <= 0, pointers <= 0, `pending` <= 0.
  - `fetch_pc` <= {redirect_target[31:2], 2'b00}.
  - No issue that cycle.
- `fetch_pc` wraps from 32'hFFFF_FFFC to 0. `mem_addr` uses only bits [15:2].
- RESET: `fetch_pc` <= RESET_PC; count, pointers and `pending` <= 0. A response arriving the cycle after reset is dropped because `pending` = 0.
- RESET during an outstanding read or a redirect: RESET wins, and the state equals the post-reset state.

## Timing
- Reset values: `mem_rden` = 0 during the RESET cycle. `out_valid` = 0, `out_ir`/`out_pc` = 0, `occupancy` = 0.
- First fetch: `mem_rden` = 1 with `mem_addr` = RESET_PC[15:2] in the first cycle after RESET deasserts (cycle 0). Data returns in cycle 1 and is pushed at the end of cycle 1. `out_valid` = 1 in cycle 2 (cycle 1 when bypass is enabled).
- Redirect in cycle t: target issued in t+1, data in t+2, `out_valid` in t+3 (t+2 with bypass). Redirect penalty is measured from the redirect cycle.
- Sustains one instruction per cycle while `stall_D` = 0.
- While stalled, the FIFO fills to DEPTH, then issue stops. Issue restarts the cycle after a pop lowers count + pending below DEPTH.
- `out_valid`, `out_ir`, `out_pc` come directly from the registered FIFO head when bypass is disabled.

## Configuration
- `OTTER_FETCH_BYPASS_EN` defined:
  - When count = 0 and a response is being accepted (`pending` & ~`redirect`), it is presented on `out_*` combinationally in the same cycle.
  - If it is also popped (~`stall_D`), it is not written to the FIFO.
  - This saves one cycle of fetch latency and redirect penalty, at the cost of a `mem_rdata`→`out_ir` combinational path.
- Not defined: all outputs come from FIFO registers only. Latencies are as in Timing without bypass.

## Test plan
- Reset, RESET_PC = 0, no stalls, memory word n = n: `out_pc` sequence 0,4,8,… with `out_ir` 0,1,2,…. `out_valid` first at cycle 2 (1 with bypass), then every cycle.
- Hold `stall_D` = 1 for 10 cycles: `occupancy` saturates at 4, `mem_rden` = 0 once count + pending = 4, and the head is held at the same PC. Release: PCs continue with no gap or duplicate.
- Redirect to 32'h0000_0102 while count = 3 and a read is pending: `occupancy` = 0 next cycle, the pending data is never output, `mem_addr` = 0x40 at t+1, and the next `out_pc` = 32'h100.
- Redirect and `stall_D` asserted together with a full FIFO: the flush occurs and there is no pop. Redirect plus RESET together: `fetch_pc` = RESET_PC.
- RESET asserted one cycle after an issue: no output appears for the dropped response, and the restart is identical to the initial reset.
- Fetch at 32'hFFFF_FFFC: the next `out_pc` = 0, and `mem_addr` wraps from 0x3FFF to 0x0000.
